pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Measures an incoming PWM waveform, which is the receive-side counterpart of the team's triangle-counter PWM generator. It samples an asynchronous PWM input on Clock and reports, once per period, the high time and period in Clock cycles. Typical uses are loop-back checking of generated PWM and decoding external PWM commands. It detects a stuck line (0 % or 100 % duty) by timeout.

Parameters:
WIDTH, 12, width of the counters and measurement outputs
TIMEOUT, 4095, cycles without a rising edge before timeout is declared; must be 2..2^WIDTH-1

Ports:
Clock     input   1      system clock, all logic on rising edge
Reset     input   1      asynchronous, active-high reset
PWM_i     input   1      asynchronous PWM input
High_o    output  WIDTH  high time of the last complete period, in cycles
Period_o  output  WIDTH  length of the last complete period (rise to rise), in cycles
Valid_o   output  1      one-cycle pulse when High_o/Period_o update with a new measurement
Timeout_o output  1      set on timeout; cleared on the next Valid_o
Level_o   output  1      filtered input level (s_lvl)

Behaviour:
- Reset (async, active-high): all sync flops, counters and outputs are 0; state = IDLE.
- Sync: 2-flop synchroniser, then one history flop. s_lvl is the synchronised level (filtered when the macro is enabled).
- Edge detect: rise = s_lvl & ~s_prev; fall = ~s_lvl & s_prev.
- Latency (no filter): a PWM_i change sampled at edge n is acted on at edge n+2, and Valid_o is high in the cycle after edge n+2.
- State machine (IDLE, HIGH, LOW):
  - IDLE: counters held at 0. On rise: go to HIGH, per_cnt<=1, hi_cnt<=1, no Valid_o, because the first period is incomplete.
  - HIGH: on fall, go to LOW.
  - LOW: on rise, go to HIGH, Period_o<=per_cnt, High_o<=hi_cnt, Valid_o<=1, Timeout_o<=0, per_cnt<=1, hi_cnt<=1.
  - In HIGH and LOW on any other edge: per_cnt<=per_cnt+1; hi_cnt<=hi_cnt+s_lvl. Both saturate at 2^WIDTH-1.
  - A waveform with H high and L low cycles therefore reports High_o=H and Period_o=H+L.
- Timeout: in HIGH or LOW, if per_cnt==TIMEOUT and there is no rise on that edge:
  - Timeout_o<=1, High_o<=0, Period_o<=0, no Valid_o.
  - Go to IDLE. Level_o shows the stuck level.
- Simultaneous rise and timeout on the same edge: rise wins, and a normal measurement is made.
- A rise seen in HIGH cannot occur, since an edge requires a level change. A fall in IDLE or LOW is ignored.
- Valid_o is never high for two consecutive cycles. High_o and Period_o hold their values between updates.
- High_o <= Period_o always holds.
- Reset asserted mid-measurement: the partial measurement is discarded. After release, the first rise restarts from IDLE.

Optional Feature:
PWM_CAPTURE_FILTER_EN
- Defined: a glitch filter sits between the synchroniser and s_lvl.
  - s_lvl changes only after 3 consecutive identical synchronised samples that differ from s_lvl.
  - This adds 2 cycles of latency. Pulses or gaps shorter than 3 cycles are rejected.
  - Filter flops reset to 0.
- Undefined: s_lvl is the synchroniser output directly. Latency and behaviour are as above.

Test Plan:
1. Reset, then drive PWM_i periodic with H=3, L=5 for 4 periods -> no Valid_o after the first rise; afterwards Valid_o pulses every 8 cycles with High_o=3, Period_o=8, Timeout_o=0.
2. Switch mid-run from H=3/L=5 to H=10/L=2 -> the first complete new period reports 10/12, with no intermediate garbage value other than the transition period.
3. Hold PWM_i=1 after one rise -> Timeout_o=1 exactly TIMEOUT cycles after that rise is acted on; High_o=0, Period_o=0, Level_o=1. Then resume H=4/L=4 -> Timeout_o clears with the first Valid_o (4/8).
4. Assert Reset for 1 cycle in the middle of a high phase -> outputs are 0 immediately (async); the next full period after release reports correct values, with the first period suppressed.
5. With the macro: a 1-cycle and a 2-cycle low glitch inside H=20/L=20 -> High_o=20, Period_o=40, no extra Valid_o. Without the macro: the 1-cycle glitch produces a Valid_o with a shortened Period_o.
6. TIMEOUT=8, H=3/L=5 (rise coincides with per_cnt==8) -> normal Valid_o with 3/8, Timeout_o stays 0.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM waveform.
//
// PWM_i is synchronised into the Clock domain and edge-detected. Once per
// complete period (rise to rise) the high time and the period length, both in
// Clock cycles, are published on High_o/Period_o with a one-cycle Valid_o
// strobe. The first period after reset or after a timeout is incomplete and is
// never reported. If no rising edge arrives within TIMEOUT cycles of the last
// one, Timeout_o is raised, the measurement outputs are zeroed and the block
// waits for a fresh rise.
//
// Optional build macro: PWM_CAPTURE_FILTER_EN
//   Defined   - a 3-sample glitch filter sits between the synchroniser and the
//               internal level; pulses or gaps shorter than 3 cycles are
//               ignored and the measurement latency grows by 2 cycles.
//   Undefined - the synchroniser output is used directly.
//
// Parameters:
//   WIDTH    width of the cycle counters and measurement outputs
//   TIMEOUT  cycles without a rise before timeout (2 .. 2**WIDTH-1)
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   PWM_i      in   asynchronous PWM input
//   High_o     out  high time of the last complete period
//   Period_o   out  length of the last complete period
//   Valid_o    out  one-cycle pulse when High_o/Period_o update
//   Timeout_o  out  set on timeout, cleared by the next Valid_o
//   Level_o    out  synchronised (and optionally filtered) input level
//
// The internal state register state_q is visible for debug probes.

module pwm_capture #(
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             PWM_i,
    output logic [WIDTH-1:0] High_o,
    output logic [WIDTH-1:0] Period_o,
    output logic             Valid_o,
    output logic             Timeout_o,
    output logic             Level_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    // Synchroniser and edge-detect history.
    logic sync1_q, sync2_q, prev_q;
    logic s_lvl;
    logic rise, fall;

    // Measurement state.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] per_inc, hi_inc;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= PWM_i;
            sync2_q <= sync1_q;
            prev_q  <= s_lvl;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // The level follows the synchroniser only when the current sample and the
    // two before it agree; otherwise the last accepted level is held. Using the
    // current sample combinationally keeps the extra latency at 2 cycles.
    logic f1_q, f2_q, filt_q;
    logic agree;

    assign agree = (sync2_q == f1_q) && (f1_q == f2_q);
    assign s_lvl = agree ? sync2_q : filt_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            f1_q   <= 1'b0;
            f2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            f1_q   <= sync2_q;
            f2_q   <= f1_q;
            filt_q <= s_lvl;
        end
    end
`else
    assign s_lvl = sync2_q;
`endif

    assign rise = s_lvl & ~prev_q;
    assign fall = ~s_lvl & prev_q;

    // Saturating counters: the period counter counts every cycle, the high
    // counter only the cycles in which the level is high.
    assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + CNT_ONE;
    assign hi_inc  = (s_lvl && (hi_q != CNT_MAX)) ? hi_q + CNT_ONE : hi_q;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                per_d = '0;
                hi_d  = '0;
                if (rise) begin
                    state_d = ST_HIGH;
                    per_d   = CNT_ONE;
                    hi_d    = CNT_ONE;
                end
            end
            ST_HIGH, ST_LOW: begin
                // A rise closes the period; it takes priority over a timeout
                // reached on the same edge.
                if ((state_q == ST_LOW) && rise) begin
                    state_d   = ST_HIGH;
                    high_d    = hi_q;
                    period_d  = per_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    per_d     = CNT_ONE;
                    hi_d      = CNT_ONE;
                end else if (per_q == TIMEOUT_V) begin
                    state_d   = ST_IDLE;
                    high_d    = '0;
                    period_d  = '0;
                    timeout_d = 1'b1;
                    per_d     = '0;
                    hi_d      = '0;
                end else begin
                    if ((state_q == ST_HIGH) && fall) begin
                        state_d = ST_LOW;
                    end
                    per_d = per_inc;
                    hi_d  = hi_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                per_d   = '0;
                hi_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            per_q     <= '0;
            hi_q      <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            hi_q      <= hi_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign High_o    = high_q;
    assign Period_o  = period_q;
    assign Valid_o   = valid_q;
    assign Timeout_o = timeout_q;
    assign Level_o   = s_lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture.
//
// The waveform is described as periods of H high and L low cycles. Every
// period that is closed by a following rise must be reported as {H, H+L}; the
// driver queues that expectation when it starts the closing rise and a monitor
// matches every Valid_o against the queue in order. Timeout, reset and a
// second instance with a tiny TIMEOUT cover the multi-cycle corner cases.

module tb_pwm_capture;

  localparam int WIDTH = 12;
  localparam int TMO   = 60;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic pwm;
  logic pwm8;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] high_o, period_o;
  logic             valid_o, timeout_o, level_o;
  logic [WIDTH-1:0] high8, period8;
  logic             valid8, timeout8, level8;

  pwm_capture #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .PWM_i    (pwm),
    .High_o   (high_o),
    .Period_o (period_o),
    .Valid_o  (valid_o),
    .Timeout_o(timeout_o),
    .Level_o  (level_o)
  );

  pwm_capture #(.WIDTH(WIDTH), .TIMEOUT(8)) dut8 (
    .Clock    (clk),
    .Reset    (rst),
    .PWM_i    (pwm8),
    .High_o   (high8),
    .Period_o (period8),
    .Valid_o  (valid8),
    .Timeout_o(timeout8),
    .Level_o  (level8)
  );

  // ---------------- scoreboard ----------------
  logic [2*WIDTH-1:0] exp_q[$];  // {high, period}
  int n_cmp;
  int n_err;
  int pend_h;
  int pend_p;
  bit pend_ok;

  typedef struct {
    int h;
    int l;
    int n;
    int exp_h;
    int exp_p;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the level for n rising edges.
  task automatic drive_raw(input logic lvl, input int n);
    pwm = lvl;
    repeat (n) @(negedge clk);
  endtask

  // One period; the rise that starts it closes the previous open period.
  task automatic drive_period(input int h, input int l, input int eh, input int ep);
    if (pend_ok) exp_q.push_back({WIDTH'(pend_h), WIDTH'(pend_p)});
    drive_raw(1'b1, h);
    drive_raw(1'b0, l);
    pend_h  = eh;
    pend_p  = ep;
    pend_ok = 1'b1;
  endtask

  task automatic close_pending();
    if (pend_ok) exp_q.push_back({WIDTH'(pend_h), WIDTH'(pend_p)});
    pend_ok = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic prev_v;
    logic [2*WIDTH-1:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && valid_o) begin
        check("valid_single_cycle", int'(prev_v), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got high=%0d period=%0d, required no Valid_o (t=%0t)",
                   high_o, period_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("high", int'(high_o), int'(e[2*WIDTH-1:WIDTH]));
          check("period", int'(period_o), int'(e[WIDTH-1:0]));
          check("timeout_cleared_on_valid", int'(timeout_o), 0);
          check("high_le_period", int'(high_o <= period_o), 1);
        end
      end
      prev_v = valid_o;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int h;
    int l;
    int v8;
    bit t8;
    n_cmp   = 0;
    n_err   = 0;
    pend_ok = 1'b0;
    pend_h  = 0;
    pend_p  = 0;
    rst     = 1'b1;
    pwm     = 1'b0;
    pwm8    = 1'b0;
    fork
      monitor();
    join_none

    #1;
    check("reset_high", int'(high_o), 0);
    check("reset_period", int'(period_o), 0);
    check("reset_valid", int'(valid_o), 0);
    check("reset_timeout", int'(timeout_o), 0);
    check("reset_level", int'(level_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven periodic waveforms, including a mid-run switch 3/5 -> 10/2.
    vecs[0] = '{h: 3,  l: 5,  n: 4, exp_h: 3,  exp_p: 8};
    vecs[1] = '{h: 10, l: 2,  n: 3, exp_h: 10, exp_p: 12};
    vecs[2] = '{h: 4,  l: 4,  n: 2, exp_h: 4,  exp_p: 8};
    vecs[3] = '{h: 20, l: 20, n: 2, exp_h: 20, exp_p: 40};
    vecs[4] = '{h: 3,  l: 3,  n: 3, exp_h: 3,  exp_p: 6};
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        drive_period(vecs[i].h, vecs[i].l, vecs[i].exp_h, vecs[i].exp_p);
      end
    end

    // Randomised periods against the {H, H+L} rule.
    for (int i = 0; i < 25; i++) begin
      h = int'($urandom_range(3, 20));
      l = int'($urandom_range(3, 20));
      drive_period(h, l, h, h + l);
    end

    // Short low glitches inside a 20/20 waveform.
`ifdef PWM_CAPTURE_FILTER_EN
    close_pending();
    drive_raw(1'b1, 8);
    drive_raw(1'b0, 1);
    drive_raw(1'b1, 11);
    drive_raw(1'b0, 20);
    exp_q.push_back({WIDTH'(20), WIDTH'(40)});
    drive_raw(1'b1, 8);
    drive_raw(1'b0, 2);
    drive_raw(1'b1, 10);
    drive_raw(1'b0, 20);
    pend_h  = 20;
    pend_p  = 40;
    pend_ok = 1'b1;
`else
    drive_period(8, 1, 8, 9);
    drive_period(11, 20, 11, 31);
    drive_period(8, 2, 8, 10);
    drive_period(10, 20, 10, 30);
`endif
    drive_period(5, 5, 5, 10);

    // Stuck high: the rise closes the open period, then timeout.
    close_pending();
    pwm = 1'b1;
    repeat (LAT + TMO) @(negedge clk);
    check("timeout_not_early", int'(timeout_o), 0);
    @(negedge clk);
    check("timeout_set", int'(timeout_o), 1);
    check("timeout_high_zero", int'(high_o), 0);
    check("timeout_period_zero", int'(period_o), 0);
    check("timeout_level_high", int'(level_o), 1);
    check("timeout_queue_drained", exp_q.size(), 0);
    drive_raw(1'b1, 5);
    check("timeout_held", int'(timeout_o), 1);
    drive_raw(1'b0, 4);
    drive_period(4, 4, 4, 8);
    check("timeout_held_first_period", int'(timeout_o), 1);
    drive_period(4, 4, 4, 8);
    check("timeout_cleared", int'(timeout_o), 0);
    drive_period(4, 4, 4, 8);

    // Reset pulse in the middle of a high phase.
    close_pending();
    drive_raw(1'b1, 8);
    rst = 1'b1;
    #1;
    check("midreset_high", int'(high_o), 0);
    check("midreset_period", int'(period_o), 0);
    check("midreset_timeout", int'(timeout_o), 0);
    check("midreset_level", int'(level_o), 0);
    @(negedge clk);
    rst = 1'b0;
    check("midreset_queue_drained", exp_q.size(), 0);
    // The still-high input appears as a fresh rise: 5 high + 6 low cycles.
    drive_raw(1'b1, 5);
    drive_raw(1'b0, 6);
    pend_h  = 5;
    pend_p  = 11;
    pend_ok = 1'b1;
    for (int i = 0; i < 3; i++) drive_period(5, 7, 5, 12);
    close_pending();
    drive_raw(1'b1, 10);
    drive_raw(1'b0, 10);

    // TIMEOUT=8 instance: the closing rise lands on per_cnt==TIMEOUT.
    v8 = 0;
    t8 = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 8; c++) begin
        pwm8 = (c < 3);
        @(negedge clk);
        if (valid8) begin
          v8++;
          check("t8_high", int'(high8), 3);
          check("t8_period", int'(period8), 8);
        end
        if (timeout8) t8 = 1'b1;
      end
    end
    check("t8_valid_count", v8, 4);
    check("t8_no_timeout", int'(t8), 0);

    repeat (10) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
